// File: rtl/cam_decimate_writer.sv
// ---------------------------------------------------------------------------
// cam_decimate_writer
//
// Takes the assembled RGB565 camera pixel stream and writes a 4x decimated
// copy of each frame into the display frame buffer.  Horizontally every
// group of 2**DEC_LOG2 pixels is box-averaged per colour channel;
// vertically only rows with sy[DEC_LOG2-1:0] == 0 are kept.
//
// Ports
//   clk         capture-domain clock
//   rst_n       asynchronous active-low reset
//   pix_in      RGB565 pixel {R[4:0], G[5:0], B[4:0]}
//   pix_valid   pix_in valid this cycle
//   in_sof      one-cycle start-of-frame pulse
//   in_eol      one-cycle end-of-line pulse
//   we          buffer write enable, one cycle per destination pixel
//   waddr       buffer write address
//   wdata       averaged RGB565 pixel
//   frame_done  pulse alongside the last destination write of a frame
//   line_err    sticky malformed-line flag, cleared by in_sof
//   frame_cnt   completed frame count, wraps
// ---------------------------------------------------------------------------
module cam_decimate_writer #(
   parameter int SRC_W    = 640,
   parameter int SRC_H    = 480,
   parameter int DEC_LOG2 = 2,
   parameter int DST_W    = SRC_W >> DEC_LOG2,
   parameter int DST_H    = SRC_H >> DEC_LOG2,
   parameter int ADDR_W   = 15,
   parameter int MIRROR_X = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [15:0]       pix_in,
   input  logic              pix_valid,
   input  logic              in_sof,
   input  logic              in_eol,
   output logic              we,
   output logic [ADDR_W-1:0] waddr,
   output logic [15:0]       wdata,
   output logic              frame_done,
   output logic              line_err,
   output logic [7:0]        frame_cnt
);

   localparam int SX_W = $clog2(SRC_W + 1);
   localparam int SY_W = $clog2(SRC_H + 1);
   localparam int RB_W = 5 + DEC_LOG2;
   localparam int G_W  = 6 + DEC_LOG2;

   localparam logic [SX_W-1:0]   SX_END  = SX_W'(SRC_W);
   localparam logic [SY_W-1:0]   SY_END  = SY_W'(SRC_H);
   localparam logic [ADDR_W-1:0] DST_W_V = ADDR_W'(DST_W);
   localparam logic [ADDR_W-1:0] X_LAST  = ADDR_W'(DST_W - 1);
   localparam logic [ADDR_W-1:0] Y_LAST  = ADDR_W'(DST_H - 1);

   // Row base address yd*DST_W as a constant shift-add: one adder per set
   // bit of DST_W, e.g. (yd<<7)+(yd<<5) for a 160 pixel wide buffer.
   function automatic logic [ADDR_W-1:0] mul_dst_w(input logic [ADDR_W-1:0] y);
      logic [ADDR_W-1:0] acc;
      acc = '0;
      for (int i = 0; i < ADDR_W; i++) begin
         if (DST_W_V[i]) acc = acc + (y << i);
      end
      return acc;
   endfunction

   logic              active_q, active_d;
   logic [SX_W-1:0]   sx_q, sx_d;
   logic [SY_W-1:0]   sy_q, sy_d;
   logic [RB_W-1:0]   acc_r_q, acc_r_d;
   logic [G_W-1:0]    acc_g_q, acc_g_d;
   logic [RB_W-1:0]   acc_b_q, acc_b_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] waddr_q, waddr_d;
   logic [15:0]       wdata_q, wdata_d;
   logic              frame_done_q, frame_done_d;
   logic              line_err_q, line_err_d;
   logic [7:0]        frame_cnt_q, frame_cnt_d;

   logic [RB_W-1:0]   sum_r, sum_b;
   logic [G_W-1:0]    sum_g;
   logic [ADDR_W-1:0] xd_a, yd_a, xo_a;

   always_comb begin
      active_d     = active_q;
      sx_d         = sx_q;
      sy_d         = sy_q;
      acc_r_d      = acc_r_q;
      acc_g_d      = acc_g_q;
      acc_b_d      = acc_b_q;
      line_err_d   = line_err_q;
      we_d         = 1'b0;
      waddr_d      = waddr_q;
      wdata_d      = wdata_q;
      frame_done_d = 1'b0;
      frame_cnt_d  = frame_cnt_q + {7'd0, frame_done_q};
      sum_r        = '0;
      sum_g        = '0;
      sum_b        = '0;
      xd_a         = '0;
      yd_a         = '0;
      xo_a         = '0;

      // Start of frame resets position first, so a pixel arriving in the
      // same cycle lands at (0,0) of the new frame.
      if (in_sof) begin
         active_d   = 1'b1;
         sx_d       = '0;
         sy_d       = '0;
         acc_r_d    = '0;
         acc_g_d    = '0;
         acc_b_d    = '0;
         line_err_d = 1'b0;
      end

      if (active_d) begin
         if (pix_valid && (sy_d < SY_END)) begin
            if (sx_d < SX_END) begin
               sum_r = acc_r_d + RB_W'(pix_in[15:11]);
               sum_g = acc_g_d + G_W'(pix_in[10:5]);
               sum_b = acc_b_d + RB_W'(pix_in[4:0]);
               xd_a  = ADDR_W'(sx_d >> DEC_LOG2);
               yd_a  = ADDR_W'(sy_d >> DEC_LOG2);
               xo_a  = (MIRROR_X != 0) ? (X_LAST - xd_a) : xd_a;
               if (sy_d[DEC_LOG2-1:0] == '0) begin
                  if (&sx_d[DEC_LOG2-1:0]) begin
                     // Group complete: emit the average and restart the
                     // accumulators from zero for the next group.
                     we_d         = 1'b1;
                     wdata_d      = {sum_r[RB_W-1:DEC_LOG2],
                                     sum_g[G_W-1:DEC_LOG2],
                                     sum_b[RB_W-1:DEC_LOG2]};
                     waddr_d      = mul_dst_w(yd_a) + xo_a;
                     frame_done_d = (xd_a == X_LAST) && (yd_a == Y_LAST);
                     acc_r_d      = '0;
                     acc_g_d      = '0;
                     acc_b_d      = '0;
                  end else begin
                     acc_r_d = sum_r;
                     acc_g_d = sum_g;
                     acc_b_d = sum_b;
                  end
               end
               sx_d = sx_d + SX_W'(1);
            end else begin
               line_err_d = 1'b1;
            end
         end

         // End of line is applied after any pixel of the same cycle, so the
         // length check sees that pixel.
         if (in_eol && !in_sof) begin
            if (sy_d < SY_END) begin
               if (sx_d != SX_END) line_err_d = 1'b1;
               sy_d = sy_d + SY_W'(1);
            end
            sx_d    = '0;
            acc_r_d = '0;
            acc_g_d = '0;
            acc_b_d = '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active_q     <= 1'b0;
         sx_q         <= '0;
         sy_q         <= '0;
         acc_r_q      <= '0;
         acc_g_q      <= '0;
         acc_b_q      <= '0;
         we_q         <= 1'b0;
         waddr_q      <= '0;
         wdata_q      <= '0;
         frame_done_q <= 1'b0;
         line_err_q   <= 1'b0;
         frame_cnt_q  <= '0;
      end else begin
         active_q     <= active_d;
         sx_q         <= sx_d;
         sy_q         <= sy_d;
         acc_r_q      <= acc_r_d;
         acc_g_q      <= acc_g_d;
         acc_b_q      <= acc_b_d;
         we_q         <= we_d;
         waddr_q      <= waddr_d;
         wdata_q      <= wdata_d;
         frame_done_q <= frame_done_d;
         line_err_q   <= line_err_d;
         frame_cnt_q  <= frame_cnt_d;
      end
   end

   assign we         = we_q;
   assign waddr      = waddr_q;
   assign wdata      = wdata_q;
   assign frame_done = frame_done_q;
   assign line_err   = line_err_q;
   assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_cam_decimate_writer.sv
// ---------------------------------------------------------------------------
// tb_cam_decimate_writer
//
// Directed bench for cam_decimate_writer.  The DUT runs a reduced 64x48
// source geometry (16x12 destination) so a whole frame fits in a short run;
// all address and data expectations are worked out for that geometry with
// MIRROR_X = 1.
// ---------------------------------------------------------------------------
module tb_cam_decimate_writer;

   localparam int SW = 64;
   localparam int SH = 48;
   localparam int DW = 16;
   localparam int DH = 12;
   localparam int NW = DW * DH;
   localparam int AW = 15;

   logic          clk;
   logic          rst_n;
   logic [15:0]   pix_in;
   logic          pix_valid;
   logic          in_sof;
   logic          in_eol;
   logic          we;
   logic [AW-1:0] waddr;
   logic [15:0]   wdata;
   logic          frame_done;
   logic          line_err;
   logic [7:0]    frame_cnt;

   cam_decimate_writer #(
      .SRC_W(SW), .SRC_H(SH), .DEC_LOG2(2), .DST_W(DW), .DST_H(DH),
      .ADDR_W(AW), .MIRROR_X(1)
   ) dut (
      .clk(clk), .rst_n(rst_n), .pix_in(pix_in), .pix_valid(pix_valid),
      .in_sof(in_sof), .in_eol(in_eol), .we(we), .waddr(waddr),
      .wdata(wdata), .frame_done(frame_done), .line_err(line_err),
      .frame_cnt(frame_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   int we_cnt  = 0;
   int fd_cnt  = 0;
   int fd_bad  = 0;
   int fd_addr = -1;
   int oob     = 0;
   bit rec_en  = 1'b0;
   int cov[NW];

   always @(negedge clk) begin
      if (we) begin
         we_cnt++;
         if (rec_en) begin
            if (int'(waddr) < NW) cov[int'(waddr)]++;
            else oob++;
         end
      end
      if (frame_done) begin
         fd_cnt++;
         fd_addr = int'(waddr);
         if (!we) fd_bad++;
      end
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic cyc(input logic v, input logic [15:0] d, input logic s, input logic e);
      pix_valid = v;
      pix_in    = d;
      in_sof    = s;
      in_eol    = e;
      @(posedge clk);
      #1;
      pix_valid = 1'b0;
      in_sof    = 1'b0;
      in_eol    = 1'b0;
   endtask

   // n pixels then a one-cycle eol gap; pat selects (row<<5)|col[4:0]
   task automatic line(input int n, input int r, input bit pat, input logic [15:0] k);
      for (int c = 0; c < n; c++)
         cyc(1'b1, pat ? 16'((r << 5) | (c & 31)) : k, 1'b0, 1'b0);
      cyc(1'b0, 16'h0, 1'b0, 1'b1);
   endtask

   task automatic settle();
      @(negedge clk);
      #1;
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      int bad;

      rst_n = 1'b0; pix_in = '0; pix_valid = 1'b0; in_sof = 1'b0; in_eol = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_we",        32'(we),         32'd0);
      check("rst_waddr",     32'(waddr),      32'd0);
      check("rst_wdata",     32'(wdata),      32'd0);
      check("rst_frame_done",32'(frame_done), 32'd0);
      check("rst_line_err",  32'(line_err),   32'd0);
      check("rst_frame_cnt", 32'(frame_cnt),  32'd0);
      rst_n = 1'b1;

      // pixels before any in_sof are ignored
      for (int i = 0; i < 8; i++) cyc(1'b1, 16'h0841, 1'b0, 1'b0);
      settle();
      check("pre_sof_we_cnt", 32'(we_cnt), 32'd0);
      check("pre_sof_frame_cnt", 32'(frame_cnt), 32'd0);

      // first group average
      cyc(1'b0, 16'h0, 1'b1, 1'b0);
      cyc(1'b1, 16'h0841, 1'b0, 1'b0);
      cyc(1'b1, 16'h0841, 1'b0, 1'b0);
      cyc(1'b1, 16'h1082, 1'b0, 1'b0);
      check("grp_early_we", 32'(we), 32'd0);
      cyc(1'b1, 16'h1082, 1'b0, 1'b0);
      check("grp_we",    32'(we),    32'd1);
      check("grp_wdata", 32'(wdata), 32'h0861);
      check("grp_waddr", 32'(waddr), 32'(DW - 1));

      // rows 1-3 never write; row 4 group 0 goes to the next buffer row
      cyc(1'b0, 16'h0, 1'b1, 1'b0);
      line(SW, 0, 1'b0, 16'h0841);
      settle();
      base = we_cnt;
      for (int r = 1; r < 4; r++) line(SW, r, 1'b0, 16'h0841);
      settle();
      check("skip_rows_we", 32'(we_cnt - base), 32'd0);
      for (int i = 0; i < 4; i++) cyc(1'b1, 16'h0841, 1'b0, 1'b0);
      check("row4_we",    32'(we),    32'd1);
      check("row4_waddr", 32'(waddr), 32'(2 * DW - 1));
      check("row4_wdata", 32'(wdata), 32'h0841);

      // whole frame
      settle();
      check("pre_frame_cnt", 32'(frame_cnt), 32'd0);
      cyc(1'b0, 16'h0, 1'b1, 1'b0);
      settle();
      base   = we_cnt;
      rec_en = 1'b1;
      for (int r = 0; r < SH; r++) line(SW, r, 1'b1, 16'h0);
      settle();
      rec_en = 1'b0;
      bad = oob;
      for (int i = 0; i < NW; i++) if (cov[i] != 1) bad++;
      check("frame_we_cnt",    32'(we_cnt - base), 32'(NW));
      check("frame_cover",     32'(bad),           32'd0);
      check("frame_done_cnt",  32'(fd_cnt),        32'd1);
      check("frame_done_addr", 32'(fd_addr),       32'((DH - 1) * DW));
      check("frame_done_we",   32'(fd_bad),        32'd0);
      check("frame_cnt",       32'(frame_cnt),     32'd1);
      check("frame_line_err",  32'(line_err),      32'd0);

      // empty line and short line
      cyc(1'b0, 16'h0, 1'b1, 1'b0);
      cyc(1'b0, 16'h0, 1'b0, 1'b1);
      check("empty_line_err", 32'(line_err), 32'd1);
      cyc(1'b0, 16'h0, 1'b1, 1'b0);
      check("sof_clears_err", 32'(line_err), 32'd0);
      settle();
      base = we_cnt;
      line(SW - 2, 0, 1'b0, 16'h0841);
      settle();
      check("short_we_cnt",   32'(we_cnt - base), 32'(DW - 1));
      check("short_last_addr",32'(waddr),         32'd1);
      check("short_line_err", 32'(line_err),      32'd1);
      base = we_cnt;
      for (int r = 1; r < 5; r++) line(SW, r, 1'b0, 16'h0841);
      settle();
      check("after_short_we_cnt", 32'(we_cnt - base), 32'(DW));
      check("after_short_wdata",  32'(wdata),         32'h0841);
      check("err_sticky",         32'(line_err),      32'd1);
      cyc(1'b0, 16'h0, 1'b1, 1'b0);
      check("sof_clears_err2", 32'(line_err), 32'd0);

      // long line
      settle();
      base = we_cnt;
      line(SW + 1, 0, 1'b0, 16'h0841);
      settle();
      check("long_we_cnt",   32'(we_cnt - base), 32'(DW));
      check("long_line_err", 32'(line_err),      32'd1);

      // in_sof with a pixel mid-frame: that pixel starts the new frame
      cyc(1'b0, 16'h0, 1'b1, 1'b0);
      for (int i = 0; i < 6; i++) cyc(1'b1, 16'hFFFF, 1'b0, 1'b0);
      cyc(1'b1, 16'h0000, 1'b1, 1'b0);
      cyc(1'b1, 16'h0000, 1'b0, 1'b0);
      cyc(1'b1, 16'h0000, 1'b0, 1'b0);
      check("sofpix_early_we", 32'(we), 32'd0);
      cyc(1'b1, 16'hFFFF, 1'b0, 1'b0);
      check("sofpix_we",    32'(we),    32'd1);
      check("sofpix_waddr", 32'(waddr), 32'(DW - 1));
      check("sofpix_wdata", 32'(wdata), 32'h39E7);

      // reset while a write is on the outputs
      cyc(1'b0, 16'h0, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) cyc(1'b1, 16'h0841, 1'b0, 1'b0);
      check("pre_rst_we", 32'(we), 32'd1);
      rst_n = 1'b0;
      #1;
      check("async_rst_we",        32'(we),        32'd0);
      check("async_rst_waddr",     32'(waddr),     32'd0);
      check("async_rst_frame_cnt", 32'(frame_cnt), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      settle();
      base = we_cnt;
      for (int i = 0; i < 6; i++) cyc(1'b1, 16'h0841, 1'b0, 1'b0);
      settle();
      check("post_rst_no_we", 32'(we_cnt - base), 32'd0);
      cyc(1'b0, 16'h0, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) cyc(1'b1, 16'h0841, 1'b0, 1'b0);
      check("post_rst_sof_we",    32'(we),    32'd1);
      check("post_rst_sof_waddr", 32'(waddr), 32'(DW - 1));

      settle();
      check("total_frame_done", 32'(fd_cnt), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
